// File: rtl/serial_tx_sync.sv
// Parallel-to-serial transmitter: start bit (0), DATA_WIDTH bits LSB first, stop bit (1).
// Latency: line goes low the cycle after accept; frame lasts (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready only in IDLE and outside reset; tx_data/tx_valid ignored while busy.
module serial_tx_sync #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy
);

  // Counter widths never collapse to zero bits, even for the degenerate 1-bit / 1-clock cases.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_out_q, tx_out_d;

  logic accept;
  logic div_last;

  // Ready is gated by reset so a word presented during reset is never taken.
  assign tx_ready = (state_q == S_IDLE) && !reset;
  assign busy     = (state_q != S_IDLE);
  assign tx_out   = tx_out_q;
  assign accept   = tx_valid && tx_ready;
  assign div_last = (div_q == DIV_LAST);

  // Next-state logic: the divider paces every line bit; the line value is registered one cycle ahead.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_out_d = tx_out_q;

    case (state_q)
      S_IDLE: begin
        div_d    = '0;
        bit_d    = '0;
        tx_out_d = 1'b1;
        if (accept) begin
          shift_d  = tx_data;
          state_d  = S_START;
          tx_out_d = 1'b0;
        end
      end

      S_START: begin
        if (div_last) begin
          div_d    = '0;
          state_d  = S_DATA;
          tx_out_d = shift_q[0];
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      S_DATA: begin
        if (div_last) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d    = '0;
            state_d  = S_STOP;
            tx_out_d = 1'b1;
          end else begin
            bit_d    = bit_q + BIT_ONE;
            tx_out_d = shift_d[0];
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      S_STOP: begin
        tx_out_d = 1'b1;
        if (div_last) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        div_d    = '0;
        bit_d    = '0;
        tx_out_d = 1'b1;
      end
    endcase
  end

  // State registers; reset abandons any partial frame and returns the line high immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_out_q <= tx_out_d;
    end
  end

endmodule
